mat_load_sched: RTL

MAT_LOAD_SCHED -- requirements
Module: mat_load_sched

---
 rtl/mat_load_pkg.sv | 26 ++
 rtl/byte_packer.sv | 27 ++
 rtl/mat_load_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mat_load_pkg.sv
// rtl/mat_load_pkg.sv - shared types and constants for the matrix load scheduler
package mat_load_pkg;

    typedef enum logic [2:0] {
        LOAD,
        RD_A,
        RD_B,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam int N_BANKS        = 4;
    localparam int N_DIM          = 4;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 7;

    // Upper address bits select the matrix region inside every bank
    localparam logic [1:0] REGION_A = 2'b00;
    localparam logic [1:0] REGION_B = 2'b01;

    function automatic logic [N_BANKS-1:0] bank_onehot(input logic [1:0] bank);
        return N_BANKS'(1) << bank;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian 4-byte word assembler with word-ready strobe
module byte_packer
    import mat_load_pkg::*;
(
    input  logic                          uart_clk,
    input  logic                          reset,
    input  logic [7:0]                    i_byte,
    input  logic                          i_byte_valid,
    input  logic                          i_word_last,
    output logic [8*BYTES_PER_WORD-1:0]   o_word,
    output logic                          o_word_ready
);

    // Bytes shift in from the top so the first byte ends up in bits 7:0
    always_ff @(posedge uart_clk) begin
        if (reset) begin
            o_word       <= '0;
            o_word_ready <= 1'b0;
        end else begin
            o_word_ready <= i_byte_valid && i_word_last;
            if (i_byte_valid) begin
                o_word <= {i_byte, o_word[8*BYTES_PER_WORD-1:8]};
            end
        end
    end

endmodule

// File: rtl/mat_load_sched.sv
// rtl/mat_load_sched.sv - UART matrix loader and systolic operand feeder; MAT_LOAD_TIMEOUT_EN adds the inter-byte timeout
module mat_load_sched
    import mat_load_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int DATA_W         = 32
) (
    input  logic                        uart_clk,
    input  logic                        reset,
    input  logic [7:0]                  i_byte,
    input  logic                        i_byte_valid,
    output logic [N_BANKS-1:0]          o_ram_we,
    output logic [3:0]                  o_ram_addr,
    output logic [DATA_W-1:0]           o_ram_din,
    input  logic [N_BANKS*DATA_W-1:0]   i_ram_dout,
    output logic [N_BANKS*DATA_W-1:0]   o_mm_a,
    output logic [N_BANKS*DATA_W-1:0]   o_mm_b,
    output logic                        o_mm_valid,
    input  logic                        i_mm_done,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_overrun,
    output logic                        o_timeout
);

    state_t                     r_state;
    logic [BYTE_CNT_W-1:0]      r_cnt;
    logic [1:0]                 r_k;
    logic [1:0]                 r_wr_bank;
    logic [3:0]                 r_ram_addr;
    logic [N_BANKS*DATA_W-1:0]  r_acol;
    logic [N_BANKS*DATA_W-1:0]  r_mm_b_hold;
    logic                       r_mm_valid;
    logic                       r_done;
    logic                       r_overrun;
    logic                       r_feed_pending;

    logic                       w_accept;
    logic                       w_byte_take;
    logic                       w_word_last;
    logic                       w_word_ready;
    logic                       w_expire;
    logic [4:0]                 w_widx;
    logic [DATA_W-1:0]          w_word;

    // The cycle carrying the final write still belongs to LOAD but takes no bytes
    assign w_accept    = (r_state == LOAD) && !r_feed_pending;
    assign w_byte_take = i_byte_valid && w_accept;
    assign w_word_last = (r_cnt[1:0] == 2'b11);
    assign w_widx      = r_cnt[6:2];

    byte_packer u_packer (
        .uart_clk     (uart_clk),
        .reset        (reset),
        .i_byte       (i_byte),
        .i_byte_valid (w_byte_take),
        .i_word_last  (w_word_last),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

`ifdef MAT_LOAD_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] r_idle;
    logic              r_timeout;

    assign w_expire = w_accept && !i_byte_valid && (r_cnt != '0) &&
                      (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge uart_clk) begin
        if (reset) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (!w_accept || i_byte_valid || (r_cnt == '0) || w_expire) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge uart_clk) begin
        if (reset) begin
            r_state        <= LOAD;
            r_cnt          <= '0;
            r_k            <= '0;
            r_wr_bank      <= '0;
            r_ram_addr     <= '0;
            r_acol         <= '0;
            r_mm_b_hold    <= '0;
            r_mm_valid     <= 1'b0;
            r_done         <= 1'b0;
            r_overrun      <= 1'b0;
            r_feed_pending <= 1'b0;
        end else begin
            r_mm_valid <= 1'b0;
            r_done     <= 1'b0;
            if (i_byte_valid && !w_accept) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                LOAD: begin
                    if (r_feed_pending) begin
                        r_feed_pending <= 1'b0;
                        r_k            <= '0;
                        r_ram_addr     <= {REGION_A, 2'b00};
                        r_state        <= RD_A;
                    end else if (i_byte_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        // B is stored transposed so one read returns a whole row
                        if (w_word_last) begin
                            if (!w_widx[4]) begin
                                r_wr_bank  <= w_widx[3:2];
                                r_ram_addr <= {REGION_A, w_widx[1:0]};
                            end else begin
                                r_wr_bank  <= w_widx[1:0];
                                r_ram_addr <= {REGION_B, w_widx[3:2]};
                            end
                        end
                        if (&r_cnt) begin
                            r_feed_pending <= 1'b1;
                        end
                    end else if (w_expire) begin
                        r_cnt <= '0;
                    end
                end
                RD_A: begin
                    r_ram_addr <= {REGION_B, r_k};
                    r_state    <= RD_B;
                end
                RD_B: begin
                    r_acol     <= i_ram_dout;
                    r_mm_valid <= 1'b1;
                    r_state    <= ISSUE;
                end
                ISSUE: begin
                    r_mm_b_hold <= i_ram_dout;
                    if (r_k == 2'(N_DIM - 1)) begin
                        r_state <= WAIT;
                    end else begin
                        r_k        <= r_k + 2'd1;
                        r_ram_addr <= {REGION_A, r_k + 2'd1};
                        r_state    <= RD_A;
                    end
                end
                WAIT: begin
                    if (i_mm_done) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_cnt   <= '0;
                    r_k     <= '0;
                    r_state <= LOAD;
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign o_ram_we   = w_word_ready ? bank_onehot(r_wr_bank) : '0;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_din  = w_word;
    assign o_mm_a     = r_acol;
    assign o_mm_b     = (r_state == ISSUE) ? i_ram_dout : r_mm_b_hold;
    assign o_mm_valid = r_mm_valid;
    assign o_done     = r_done;
    assign o_overrun  = r_overrun;
    assign o_busy     = (r_state != LOAD) || (r_cnt != '0) || r_feed_pending;

endmodule
